fetch_stage: RTL and testbench



---
 rtl/rv32_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 48 ++++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Definitions shared by the RV32I fetch stage and the control logic that drives it:
// next-PC select encodings, the bubble instruction and the fetch FSM states.
package rv32_pkg;

    localparam int PC_SEL_WIDTH = 2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_FOUR   = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL    = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR   = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {instr, pc} holding register for a response that arrived while
// decode was stalled. Clear takes priority over load.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        full_q,  full_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full  = full_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// and drives the IF/ID register consumed by decode/control.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [31:0]             br_target,
    input  logic [31:0]             jal_target,
    input  logic [31:0]             jalr_target,
    input  logic                    stall_if,
    input  logic                    flush_if,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    imem_rvalid,
    output logic [31:0]             instr_decode,
    output logic [31:0]             pc_decode,
    output logic                    valid_decode
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         stale_q, stale_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         if_valid_q, if_valid_d;

    logic         redirect;
    logic [31:0]  target;
    logic         req;
    logic         buf_load, buf_clear, buf_full;
    logic [31:0]  buf_instr, buf_pc;

    fetch_buffer u_buffer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .pc_in    (fetch_pc_q),
        .full     (buf_full),
        .instr    (buf_instr),
        .pc       (buf_pc)
    );

    always_comb begin
        case (pc_sel)
            PC_SEL_BRANCH: target = word_align(br_target);
            PC_SEL_JAL:    target = word_align(jal_target);
            PC_SEL_JALR:   target = word_align(jalr_target);
            default:       target = fetch_pc_q;
        endcase
    end

    // A redirect under stall is dropped; decode presents it again once unstalled.
    assign redirect = (pc_sel != PC_SEL_FOUR) && !stall_if;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        req        = 1'b0;
        imem_addr  = fetch_pc_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        // Unless something is delivered below, an unstalled IF/ID takes a bubble.
        if (!stall_if) begin
            if_instr_d = NOP_INSTR_P;
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_ISSUE: begin
                req        = 1'b1;
                imem_addr  = redirect ? target : fetch_pc_q;
                fetch_pc_d = imem_addr;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (!imem_rvalid) begin
                    if (redirect) begin
                        fetch_pc_d = target;
                        stale_d    = 1'b1;
                    end
                end else if (stale_q) begin
                    stale_d    = 1'b0;
                    req        = 1'b1;
                    imem_addr  = redirect ? target : fetch_pc_q;
                    fetch_pc_d = imem_addr;
                end else if (redirect) begin
                    req        = 1'b1;
                    imem_addr  = target;
                    fetch_pc_d = target;
                end else if (stall_if) begin
                    buf_load   = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_HOLD;
                end else begin
                    if (!flush_if) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                    end
                    req        = 1'b1;
                    imem_addr  = fetch_pc_q + 32'd4;
                    fetch_pc_d = imem_addr;
                end
            end
            S_HOLD: begin
                if (!stall_if) begin
                    req       = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = S_WAIT;
                    if (redirect) begin
                        imem_addr  = target;
                        fetch_pc_d = target;
                    end else begin
                        imem_addr = fetch_pc_q;
                        if (!flush_if && buf_full) begin
                            if_instr_d = buf_instr;
                            if_pc_d    = buf_pc;
                            if_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    assign imem_req = req && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ISSUE;
            fetch_pc_q <= RESET_PC;
            stale_q    <= 1'b0;
            if_instr_q <= NOP_INSTR_P;
            if_pc_q    <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign instr_decode = if_instr_q;
    assign pc_decode    = if_pc_q;
    assign valid_decode = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable imem model plus an in-order
// model of live fetched words predicts imem addresses and IF/ID contents.
module tb_fetch_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [PC_SEL_WIDTH-1:0] pc_sel = PC_SEL_FOUR;
    logic [31:0]             br_target = '0, jal_target = '0, jalr_target = '0;
    logic                    stall_if = 1'b0, flush_if = 1'b0;
    logic                    imem_req;
    logic [31:0]             imem_addr;
    logic [31:0]             imem_rdata = '0;
    logic                    imem_rvalid = 1'b0;
    logic [31:0]             instr_decode, pc_decode;
    logic                    valid_decode;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel),
        .br_target(br_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .stall_if(stall_if), .flush_if(flush_if),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr_decode(instr_decode), .pc_decode(pc_decode), .valid_decode(valid_decode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [31:0] addr;
        bit          arrived;
    } fetch_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          valid;
    } ifid_t;

    fetch_t fq[$];
    ifid_t  exp_q[$];
    ifid_t  exp_h;

    int n_vec = 0;
    int n_err = 0;

    // stimulus knobs applied at the next step
    logic                    s_rst = 1'b0, s_stall = 1'b0, s_flush = 1'b0;
    logic [PC_SEL_WIDTH-1:0] s_sel = PC_SEL_FOUR;
    logic [31:0]             s_br = '0, s_jal = '0, s_jalr = '0;
    int                      lat = 1;

    // imem model state
    bit          busy = 0;
    int          cnt = 0;
    int unsigned busy_id = 0, resp_id = 0, next_id = 0;
    logic [31:0] busy_addr = '0;
    bit          resp = 0;
    logic [31:0] exp_next = RESET_PC;
    int          idle = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        fetch_t      f;
        ifid_t       bubble;
        bubble.instr = NOP_INSTR;
        bubble.pc    = '0;
        bubble.valid = 0;

        @(negedge clk);
        rst = s_rst;
        if (!s_rst) begin
            fq.delete();
            busy     = 0;
            exp_next = RESET_PC;
            exp_h    = bubble;
            idle     = 0;
        end
        resp        = 0;
        imem_rvalid = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                resp        = 1;
                resp_id     = busy_id;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(busy_addr);
                busy        = 0;
            end
        end
        stall_if    = s_stall;
        flush_if    = s_flush;
        pc_sel      = s_sel;
        br_target   = s_br;
        jal_target  = s_jal;
        jalr_target = s_jalr;
        #1;

        if (!s_rst) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_instr", instr_decode, NOP_INSTR);
            chk("rst_pc", pc_decode, 32'd0);
            chk("rst_valid", {31'd0, valid_decode}, 32'd0);
            return;
        end

        redir = (s_sel != PC_SEL_FOUR) && !s_stall;
        case (s_sel)
            PC_SEL_BRANCH: tgt = s_br;
            PC_SEL_JAL:    tgt = s_jal;
            default:       tgt = s_jalr;
        endcase
        tgt[1:0] = 2'b00;

        if (resp && fq.size() > 0 && fq[0].id == resp_id) begin
            f = fq[0];
            f.arrived = 1;
            fq[0] = f;
        end

        if (!s_stall) begin
            if (redir) begin
                fq.delete();
                exp_h    = bubble;
                exp_next = tgt;
            end else if (fq.size() > 0 && fq[0].arrived) begin
                f = fq.pop_front();
                if (s_flush) exp_h = bubble;
                else begin
                    exp_h.instr = mem_word(f.addr);
                    exp_h.pc    = f.addr;
                    exp_h.valid = 1;
                end
            end else begin
                exp_h = bubble;
            end
        end

        if (imem_req) begin
            if (busy) begin
                n_vec++; n_err++;
                $display("FAIL req_overlap: got request at %h while one outstanding", imem_addr);
            end
            chk("imem_addr", imem_addr, exp_next);
            f.id = next_id; f.addr = exp_next; f.arrived = 0;
            fq.push_back(f);
            busy_id   = next_id;
            next_id++;
            busy      = 1;
            busy_addr = imem_addr;
            cnt       = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
            exp_next  = exp_next + 32'd4;
        end

        if (!imem_req && !busy && !s_stall) idle++;
        else idle = 0;
        if (idle > 4) begin
            n_vec++; n_err++;
            $display("FAIL fetch_timeout: got %0d idle cycles expected at most 4", idle);
            idle = 0;
        end

        exp_q.push_back(exp_h);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : monitor
        ifid_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ifid_valid", {31'd0, valid_decode}, {31'd0, e.valid});
                chk("ifid_instr", instr_decode, e.instr);
                if (e.valid) chk("ifid_pc", pc_decode, e.pc);
            end
        end
    end

    initial begin : driver
        s_rst = 1'b0;
        run(2);
        s_rst = 1'b1;
        lat = 1;
        run(8);

        s_stall = 1'b1;
        run(3);
        s_stall = 1'b0;
        run(4);

        lat = 3;
        run(4);
        s_sel = PC_SEL_JAL; s_jal = 32'h0000_0100;
        step();
        s_sel = PC_SEL_FOUR;
        run(10);

        s_sel = PC_SEL_BRANCH; s_br = 32'h0000_0040; s_stall = 1'b1;
        step();
        s_stall = 1'b0;
        step();
        s_sel = PC_SEL_FOUR;
        run(8);

        lat = 1;
        run(3);
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        run(4);

        s_stall = 1'b1; s_flush = 1'b1;
        run(2);
        s_stall = 1'b0; s_flush = 1'b0;
        run(3);

        s_sel = PC_SEL_JALR; s_jalr = 32'hFFFF_FFFB;
        step();
        s_sel = PC_SEL_FOUR;
        run(4);

        lat = 3;
        run(2);
        s_rst = 1'b0;
        run(2);
        s_rst = 1'b1;
        run(6);

        lat = 0;
        for (int i = 0; i < 800; i++) begin
            s_stall = ($urandom_range(0, 3) == 0);
            s_flush = ($urandom_range(0, 9) == 0);
            s_sel   = ($urandom_range(0, 9) == 0) ? PC_SEL_WIDTH'($urandom_range(1, 3)) : PC_SEL_FOUR;
            s_br    = $urandom;
            s_jal   = $urandom;
            s_jalr  = $urandom;
            step();
        end
        s_stall = 1'b0; s_flush = 1'b0; s_sel = PC_SEL_FOUR;
        run(6);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
